fmap_flatten_stream: RTL and testbench
======================================

// Module: fmap_flatten_stream
// PURPOSE
//  Downstream of the 2x2 average-pool stage. On start, snapshots the full pooled
//  feature map (HEIGHT x WIDTH, DW bits each) into an internal buffer.
//  Streams the map out row-major, one element per accepted beat, over a valid/ready
//  interface. The consumer is the fully-connected layer's MAC input.
//  Decouples the combinational pool array from the sequential FC datapath.
// PARAMETERS
//  WIDTH   14  pooled map columns (the pool stage's width/2)
//  HEIGHT  14  pooled map rows (the pool stage's height/2)
//  DW      16  element width; data is opaque and passed bit-exact
//  IW      $clog2(WIDTH*HEIGHT)  index width (localparam, 8 for defaults)
// PORTS
//  clk        in   1                  single clock, all flops on rising edge
//  rst        in   1                  synchronous, active-high reset
//  in_map     in   [DW-1:0] [HEIGHT-1:0][WIDTH-1:0]  pooled map, sampled only on accepted start
//  start      in   1                  request snapshot + stream; accepted only when idle
//  busy       out  1                  high from cycle after accepted start until last beat accepted
//  out_valid  out  1                  out_data/out_index/out_last valid
//  out_ready  in   1                  consumer accepts the beat when out_valid && out_ready
//  out_data   out  DW                 element in_map[row][col]
//  out_index  out  IW                 row*WIDTH + col, 0 .. WIDTH*HEIGHT-1
//  out_last   out  1                  high only with index WIDTH*HEIGHT-1
//  done       out  1                  one-cycle pulse, cycle after last beat accepted
// BEHAVIOUR
//  - Reset: state=IDLE; busy, out_valid, out_last, done=0; out_data, out_index=0; row, col=0.
//    The buffer contents are don't-care.
//    A reset mid-stream aborts immediately: no done pulse, and the next start begins at index 0.
//  - FSM states IDLE and STREAM.
//    IDLE->STREAM on start.
//    STREAM->IDLE on the accepted beat with out_last=1.
//  - Accepted start (IDLE && start): in_map is copied whole into the buffer on that edge.
//    Next cycle: busy=1, out_valid=1, out_index=0, out_data=in_map[0][0].
//    Latency from start to first valid is 1 cycle.
//  - Handshake: a beat transfers on the edge where out_valid && out_ready.
//    While out_valid && !out_ready, out_data, out_index and out_last hold stable.
//    out_valid never drops mid-stream; there are no bubbles while ready is held high.
//    Throughput with out_ready held high: 1 element/cycle, WIDTH*HEIGHT cycles per map.
//  - Counters: col increments on each beat; at col==WIDTH-1, col wraps to 0 and row increments.
//    out_index increments by 1 on each beat.
//  - out_data is registered from buffer[row][col] of the element being presented, not a later one.
//  - Last beat accepted: on that edge out_valid=0, busy=0, out_last=0, state=IDLE.
//    done=1 for exactly the following cycle.
//  - start while busy is ignored, with no effect on the stream or the buffer.
//    start in the done cycle is accepted normally (IDLE).
//  - in_map changes after the snapshot do not affect the stream.
//  - out_ready is a don't-care while out_valid=0.
// TESTING
//  1 rst high 2 cycles -> all outputs 0.
//    in_map[r][c]=r*14+c, start 1 cycle, ready=1 -> valid on cycle 1, out_index 0..195 consecutive,
//    out_data==out_index, out_last only at 195, done pulse 1 cycle after, busy 196 cycles.
//  2 Same map, out_ready toggling 1,0,0,1 pattern -> each element appears exactly once in order.
//    out_data/out_index stable while ready=0. Total 196 transfers.
//  3 Start, then overwrite in_map with all 16'hFFFF and pulse start at index 50
//    -> stream still outputs original values; second start ignored; exactly one done.
//  4 Assert rst when out_index==100 -> next cycle all outputs 0, no done.
//    New start with in_map=16'hA5A5 everywhere -> index restarts at 0, all data A5A5.
//  5 Back-to-back: start asserted in the done cycle -> accepted.
//    Second stream begins the next cycle at index 0 with the new snapshot.
//  6 Parameter override WIDTH=3, HEIGHT=2 -> indices 0..5, row wrap after col 2, out_last at 5.

Source files
------------

// File: rtl/fmap_flatten_stream.sv
// Snapshot a pooled feature map on start and stream it out row-major
// over valid/ready, one element per accepted beat, toward the FC MAC input.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_map [H][W][DW]     pooled map, captured only on an accepted start
//   start                 snapshot + stream request, taken only when idle
//   busy                  high while a stream is in progress
//   out_valid/out_ready   beat handshake toward the consumer
//   out_data              element currently presented
//   out_index             row*WIDTH + col of the presented element
//   out_last              marks the final element of the map
//   done                  one-cycle pulse after the last beat is accepted
module fmap_flatten_stream #(
    parameter  int WIDTH  = 14,
    parameter  int HEIGHT = 14,
    parameter  int DW     = 16,
    localparam int N      = WIDTH * HEIGHT,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [HEIGHT-1:0][WIDTH-1:0][DW-1:0]   in_map,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DW-1:0]                          out_data,
    output logic [IW-1:0]                          out_index,
    output logic                                   out_last,
    output logic                                   done
);

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;
    state_t state_n;

    logic [HEIGHT-1:0][WIDTH-1:0][DW-1:0] fbuf;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] nrow;
    logic [CW-1:0] ncol;
    logic          col_end;
    logic          take;
    logic          beat;

    assign take = (state == IDLE) && start;
    assign beat = out_valid && out_ready;

    // Position of the element after the one being presented.
    assign col_end = (col == CW'(WIDTH - 1));
    assign ncol    = col_end ? '0 : col + 1'b1;
    assign nrow    = col_end ? row + 1'b1 : row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (beat && out_last) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == STREAM);
        out_valid = (state == STREAM);
        out_last  = (state == STREAM) && (out_index == IW'(N - 1));
    end

    // Snapshot buffer; its contents are irrelevant until the next start.
    always_ff @(posedge clk) begin
        if (take) begin
            fbuf <= in_map;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            out_index <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= beat && out_last;
            if (take) begin
                // First element comes straight from the port: the
                // buffer only holds the snapshot after this edge.
                row       <= '0;
                col       <= '0;
                out_index <= '0;
                out_data  <= in_map[0][0];
            end else if (beat) begin
                if (out_last) begin
                    row       <= '0;
                    col       <= '0;
                    out_index <= '0;
                end else begin
                    row       <= nrow;
                    col       <= ncol;
                    out_index <= out_index + 1'b1;
                    out_data  <= fbuf[nrow][ncol];
                end
            end
        end
    end

endmodule

// File: tb/tb_fmap_flatten_stream.sv
// Directed bench for fmap_flatten_stream with a queue scoreboard.
// Covers default 14x14 streaming plus a 3x2 override instance.
module tb_fmap_flatten_stream;

    localparam int W = 14;
    localparam int H = 14;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0]  idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t q[$];

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic out_ready;
    logic [H-1:0][W-1:0][15:0] map;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic        out_last;
    logic        done;

    logic start2;
    logic ready2;
    logic [1:0][2:0][15:0] map2;
    logic        busy2;
    logic        v2;
    logic [15:0] d2;
    logic [2:0]  i2;
    logic        l2;
    logic        done2;

    int errors = 0;
    int checks = 0;
    int dones;
    int busy_cyc;
    int beats;

    always #5 clk = ~clk;

    fmap_flatten_stream #(.WIDTH(W), .HEIGHT(H), .DW(16)) dut (
        .clk(clk), .rst(rst), .in_map(map), .start(start),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .done(done)
    );

    fmap_flatten_stream #(.WIDTH(3), .HEIGHT(2), .DW(16)) dut2 (
        .clk(clk), .rst(rst), .in_map(map2), .start(start2),
        .busy(busy2), .out_valid(v2), .out_ready(ready2),
        .out_data(d2), .out_index(i2),
        .out_last(l2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic fill_seq(input logic [15:0] x);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                map[r][c] = 16'(r * W + c) ^ x;
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                map[r][c] = v;
    endtask

    // One clock: score the beat about to transfer, then check
    // the state the DUT shows after the edge.
    task automatic tick();
        logic  acc;
        logic  stall;
        logic  exp_done;
        logic [7:0]  hi;
        logic [15:0] hd;
        beat_t e;
        acc      = out_valid && out_ready && !rst;
        stall    = out_valid && !out_ready && !rst;
        hi       = out_index;
        hd       = out_data;
        exp_done = 1'b0;
        if (acc) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(out_index), 32'hFFFF);
            end else begin
                e = q.pop_front();
                chk("beat_index", 32'(out_index), 32'(e.idx));
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_last", 32'(out_last), 32'(e.last));
                exp_done = e.last;
                beats++;
            end
        end
        if (rst) q.delete();
        @(posedge clk);
        #1;
        if (done) dones++;
        if (busy) busy_cyc++;
        chk("done", 32'(done), 32'(exp_done));
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (stall) begin
            chk("hold_index", 32'(out_index), 32'(hi));
            chk("hold_data", 32'(out_data), 32'(hd));
        end
    endtask

    task automatic do_start();
        beat_t b;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                b.idx  = 8'(r * W + c);
                b.data = map[r][c];
                b.last = (r * W + c == N - 1);
                q.push_back(b);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1.
    task automatic run(input int mode, input int stop_at);
        int k;
        k = 0;
        while (q.size() != 0 &&
               !(out_valid && int'(out_index) == stop_at)) begin
            if (k >= 2000) begin
                chk("timeout", 32'(k), 32'(0));
                break;
            end
            if (mode == 0) out_ready = 1'b1;
            else out_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
            k++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        start2 = 1'b0;
        ready2 = 1'b0;
        fill_const(16'h0);
        map2 = '0;
        dones = 0;
        busy_cyc = 0;
        beats = 0;

        // Reset
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_last", 32'(out_last), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_index", 32'(out_index), 32'(0));
        rst = 1'b0;
        tick();

        // 1: full-rate stream
        fill_seq(16'h0);
        out_ready = 1'b1;
        dones = 0;
        busy_cyc = 0;
        do_start();
        chk("t1_first_valid", 32'(out_valid), 32'(1));
        chk("t1_first_index", 32'(out_index), 32'(0));
        run(0, -1);
        chk("t1_busy_cycles", 32'(busy_cyc), 32'(N));
        chk("t1_dones", 32'(dones), 32'(1));
        tick();

        // 2: backpressure
        dones = 0;
        beats = 0;
        do_start();
        run(1, -1);
        chk("t2_beats", 32'(beats), 32'(N));
        chk("t2_dones", 32'(dones), 32'(1));
        tick();

        // 3: map change and start while busy
        dones = 0;
        do_start();
        fill_const(16'hFFFF);
        run(0, 50);
        start = 1'b1;
        tick();
        start = 1'b0;
        run(0, -1);
        chk("t3_dones", 32'(dones), 32'(1));
        tick();

        // 4: reset mid-stream
        fill_seq(16'h0);
        dones = 0;
        do_start();
        run(0, 100);
        chk("t4_at100", 32'(out_index), 32'(100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'(0));
        chk("t4_last", 32'(out_last), 32'(0));
        chk("t4_data", 32'(out_data), 32'(0));
        chk("t4_index", 32'(out_index), 32'(0));
        tick();
        tick();
        chk("t4_no_done", 32'(dones), 32'(0));
        fill_const(16'hA5A5);
        do_start();
        chk("t4_restart_idx", 32'(out_index), 32'(0));
        run(0, -1);
        chk("t4_dones", 32'(dones), 32'(1));

        // 5: start in the done cycle
        fill_seq(16'h0);
        tick();
        do_start();
        run(0, -1);
        chk("t5_done_cycle", 32'(done), 32'(1));
        fill_seq(16'h5555);
        do_start();
        chk("t5_idx0", 32'(out_index), 32'(0));
        chk("t5_data0", 32'(out_data), 32'(16'h5555));
        run(0, -1);
        tick();

        // 6: 3x2 instance
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                map2[r][c] = 16'h100 + 16'(r * 3 + c);
        start2 = 1'b1;
        ready2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        map2 = '0;
        for (int k = 0; k < 6; k++) begin
            chk("t6_valid", 32'(v2), 32'(1));
            chk("t6_index", 32'(i2), 32'(k));
            chk("t6_data", 32'(d2), 32'(16'h100 + k));
            chk("t6_last", 32'(l2), 32'(k == 5));
            @(posedge clk);
            #1;
        end
        chk("t6_done", 32'(done2), 32'(1));
        chk("t6_idle", 32'(v2), 32'(0));
        chk("t6_busy", 32'(busy2), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
